rob_commit_ctrl: RTL and testbench

//  Sequences the reorder buffer. Owns the head and tail pointers and grants ROB entries to ID (allocation).

---
 rtl/rob_commit_ctrl_pkg.sv | 24 ++
 rtl/rob_commit_ctrl_ptr.sv | 23 ++
 rtl/rob_commit_ctrl.sv | 140 ++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_ctrl_pkg.sv
// rtl/rob_commit_ctrl_pkg.sv - shared ROB sizes, entry state encodings and write masks
package rob_commit_ctrl_pkg;

  localparam int ROB_WIDTH       = 3;
  localparam int ROB_NUM_ENTRIES = 1 << ROB_WIDTH;
  localparam int ROB_STATE_WIDTH = 3;
  localparam int DATA_SIZE       = 32;
  localparam int VADDR_WIDTH     = 32;

  // Free-entry count reported by the ROB array when nothing is in flight
  localparam logic [ROB_WIDTH:0] ROB_EMPTY_COUNT = (ROB_WIDTH + 1)'(ROB_NUM_ENTRIES);

  localparam logic [ROB_STATE_WIDTH-1:0] ROB_STATE_UNUSED          = 3'd0;
  localparam logic [ROB_STATE_WIDTH-1:0] ROB_STATE_BUSY            = 3'd1;
  localparam logic [ROB_STATE_WIDTH-1:0] ROB_STATE_EXCEPTION       = 3'd2;
  localparam logic [ROB_STATE_WIDTH-1:0] ROB_STATE_WAITING_CACHE   = 3'd3;
  localparam logic [ROB_STATE_WIDTH-1:0] ROB_STATE_ACCESSING_CACHE = 3'd4;
  localparam logic [ROB_STATE_WIDTH-1:0] ROB_STATE_COMPLETE        = 3'd5;

  // Head-entry write masks; bit 5 selects the entry state field
  localparam logic [5:0] ROB_WRITE_ENABLE_NONE  = 6'b000000;
  localparam logic [5:0] ROB_WRITE_ENABLE_STATE = 6'b100000;

endpackage

// File: rtl/rob_commit_ctrl_ptr.sv
// rtl/rob_commit_ctrl_ptr.sv - wrap-around ROB pointer with increment and clear
module rob_ptr
  import rob_commit_ctrl_pkg::*;
#(
  parameter int WIDTH = ROB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  // Clear wins over increment; the counter wraps naturally at 2**WIDTH
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - ROB allocation, in-order commit, head store and exception flush
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_req,
  output logic                       alloc_gnt,
  output logic [ROB_WIDTH-1:0]       alloc_tag,
  input  logic [ROB_WIDTH:0]         empty_entries,
  input  logic [ROB_STATE_WIDTH-1:0] state_head,
  input  logic [VADDR_WIDTH-1:0]     addr_head,
  input  logic [DATA_SIZE-1:0]       value_head,
  input  logic [VADDR_WIDTH-1:0]     PC_head,
  output logic [ROB_WIDTH-1:0]       head,
  output logic [ROB_WIDTH-1:0]       tail,
  output logic [5:0]                 write_head,
  output logic [ROB_STATE_WIDTH-1:0] state_head_write,
  output logic                       commit_valid,
  output logic                       st_req,
  output logic [VADDR_WIDTH-1:0]     st_addr,
  output logic [DATA_SIZE-1:0]       st_data,
  input  logic                       st_ack,
  output logic                       flush,
  output logic [VADDR_WIDTH-1:0]     exc_pc
);

  typedef enum logic [1:0] {
    COMMIT = 2'd0,
    STORE  = 2'd1,
    FLUSH  = 2'd2
  } commit_state_t;

  commit_state_t state_q, state_d;
  logic          head_empty;
  logic          capture_store;
  logic          capture_exc;

  assign head_empty = (empty_entries == ROB_EMPTY_COUNT);
  assign alloc_tag  = tail;

  // Commit FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COMMIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, head-entry writes, commit/store/flush strobes and allocation grant
  always_comb begin
    state_d          = state_q;
    alloc_gnt        = 1'b0;
    write_head       = ROB_WRITE_ENABLE_NONE;
    state_head_write = ROB_STATE_UNUSED;
    commit_valid     = 1'b0;
    st_req           = 1'b0;
    flush            = 1'b0;
    capture_store    = 1'b0;
    capture_exc      = 1'b0;
    case (state_q)
      COMMIT: begin
        alloc_gnt = alloc_req && (empty_entries != '0);
        if (!head_empty) begin
          case (state_head)
            ROB_STATE_COMPLETE: begin
              write_head       = ROB_WRITE_ENABLE_STATE;
              state_head_write = ROB_STATE_UNUSED;
              commit_valid     = 1'b1;
            end
            ROB_STATE_WAITING_CACHE: begin
              write_head       = ROB_WRITE_ENABLE_STATE;
              state_head_write = ROB_STATE_ACCESSING_CACHE;
              capture_store    = 1'b1;
              state_d          = STORE;
            end
            ROB_STATE_EXCEPTION: begin
              capture_exc = 1'b1;
              state_d     = FLUSH;
            end
            default: begin
            end
          endcase
        end
      end
      STORE: begin
        alloc_gnt = alloc_req && (empty_entries != '0);
        st_req    = 1'b1;
        if (st_ack) begin
          write_head       = ROB_WRITE_ENABLE_STATE;
          state_head_write = ROB_STATE_UNUSED;
          commit_valid     = 1'b1;
          state_d          = COMMIT;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = COMMIT;
      end
      default: begin
        state_d = COMMIT;
      end
    endcase
  end

  // Hold the store operands and the faulting PC stable for the cache and the front end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_addr <= '0;
      st_data <= '0;
      exc_pc  <= '0;
    end else begin
      if (capture_store) begin
        st_addr <= addr_head;
        st_data <= value_head;
      end
      if (capture_exc) begin
        exc_pc <= PC_head;
      end
    end
  end

  rob_ptr #(.WIDTH(ROB_WIDTH)) u_head_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (commit_valid),
    .ptr   (head)
  );

  rob_ptr #(.WIDTH(ROB_WIDTH)) u_tail_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (alloc_gnt),
    .ptr   (tail)
  );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - scoreboard bench for rob_commit_ctrl
module tb_rob_commit_ctrl;
  import rob_commit_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alloc_req = 1'b0;
  logic        alloc_gnt;
  logic [2:0]  alloc_tag;
  logic [3:0]  empty_entries = 4'd8;
  logic [2:0]  state_head = 3'd0;
  logic [31:0] addr_head = '0;
  logic [31:0] value_head = '0;
  logic [31:0] PC_head = '0;
  logic [2:0]  head;
  logic [2:0]  tail;
  logic [5:0]  write_head;
  logic [2:0]  state_head_write;
  logic        commit_valid;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ack = 1'b0;
  logic        flush;
  logic [31:0] exc_pc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit        gnt;
    bit [2:0]  tag;
    bit        commit;
    bit [5:0]  wh;
    bit [2:0]  shw;
    bit        st_req;
    bit [31:0] st_addr;
    bit [31:0] st_data;
    bit        flush;
    bit [31:0] exc_pc;
    bit [2:0]  head;
    bit [2:0]  tail;
  } exp_t;

  exp_t sb[$];

  // reference model: occupancy-agnostic pointers plus pending store / pending flush
  int        m_head = 0;
  int        m_tail = 0;
  bit        m_store_pending = 0;
  bit        m_flush_pending = 0;
  bit [31:0] m_st_addr = 0;
  bit [31:0] m_st_data = 0;
  bit [31:0] m_exc_pc = 0;

  rob_commit_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_req        (alloc_req),
    .alloc_gnt        (alloc_gnt),
    .alloc_tag        (alloc_tag),
    .empty_entries    (empty_entries),
    .state_head       (state_head),
    .addr_head        (addr_head),
    .value_head       (value_head),
    .PC_head          (PC_head),
    .head             (head),
    .tail             (tail),
    .write_head       (write_head),
    .state_head_write (state_head_write),
    .commit_valid     (commit_valid),
    .st_req           (st_req),
    .st_addr          (st_addr),
    .st_data          (st_data),
    .st_ack           (st_ack),
    .flush            (flush),
    .exc_pc           (exc_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model
  task automatic cyc(input bit rst, input bit areq, input int emp, input logic [2:0] st,
                     input logic [31:0] a, input logic [31:0] v, input logic [31:0] pc,
                     input bit ack);
    exp_t e;
    int   cm;
    bit   nxt_store;
    bit   nxt_flush;
    @(posedge clk);
    #1;
    reset         = rst;
    alloc_req     = areq;
    empty_entries = emp[3:0];
    state_head    = st;
    addr_head     = a;
    value_head    = v;
    PC_head       = pc;
    st_ack        = ack;

    e = '{default: 0};
    e.head    = 3'(m_head);
    e.tail    = 3'(m_tail);
    e.flush   = m_flush_pending;
    e.exc_pc  = m_exc_pc;
    e.gnt     = areq && (emp != 0) && !m_flush_pending;
    e.tag     = 3'(m_tail);
    e.st_req  = m_store_pending;
    e.st_addr = m_st_addr;
    e.st_data = m_st_data;
    cm        = 0;
    nxt_store = m_store_pending;
    nxt_flush = 0;
    if (m_flush_pending) begin
    end else if (m_store_pending) begin
      if (ack) begin
        cm = 1;
        e.wh = 6'b100000;
        e.shw = ROB_STATE_UNUSED;
        nxt_store = 0;
      end
    end else if (emp != ROB_NUM_ENTRIES) begin
      if (st == ROB_STATE_COMPLETE) begin
        cm = 1;
        e.wh = 6'b100000;
        e.shw = ROB_STATE_UNUSED;
      end else if (st == ROB_STATE_WAITING_CACHE) begin
        e.wh = 6'b100000;
        e.shw = ROB_STATE_ACCESSING_CACHE;
        nxt_store = 1;
        m_st_addr = a;
        m_st_data = v;
      end else if (st == ROB_STATE_EXCEPTION) begin
        nxt_flush = 1;
        m_exc_pc = pc;
      end
    end
    e.commit = (cm != 0);
    sb.push_back(e);

    if (rst) begin
      m_head = 0; m_tail = 0; m_store_pending = 0; m_flush_pending = 0;
      m_st_addr = 0; m_st_data = 0; m_exc_pc = 0;
    end else begin
      if (m_flush_pending) begin
        m_head = 0;
        m_tail = 0;
      end else begin
        m_head = (m_head + cm) % ROB_NUM_ENTRIES;
        m_tail = (m_tail + (e.gnt ? 1 : 0)) % ROB_NUM_ENTRIES;
      end
      m_store_pending = nxt_store;
      m_flush_pending = nxt_flush;
    end
  endtask

  // Monitor: pop the expectation for each cycle and compare what the DUT presents
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alloc_gnt", 32'(alloc_gnt), 32'(e.gnt));
        if (e.gnt) chk("alloc_tag", 32'(alloc_tag), 32'(e.tag));
        chk("commit_valid", 32'(commit_valid), 32'(e.commit));
        chk("write_head", 32'(write_head), 32'(e.wh));
        if (e.wh != 0) chk("state_head_write", 32'(state_head_write), 32'(e.shw));
        chk("st_req", 32'(st_req), 32'(e.st_req));
        if (e.st_req) begin
          chk("st_addr", st_addr, e.st_addr);
          chk("st_data", st_data, e.st_data);
        end
        chk("flush", 32'(flush), 32'(e.flush));
        if (e.flush) chk("exc_pc", exc_pc, e.exc_pc);
        chk("head", 32'(head), 32'(e.head));
        chk("tail", 32'(tail), 32'(e.tail));
      end
    end
  end

  initial begin
    int r;
    logic [2:0] st;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_head", 32'(head), 0);
    chk("rst_tail", 32'(tail), 0);
    chk("rst_gnt", 32'(alloc_gnt), 0);
    chk("rst_write_head", 32'(write_head), 0);
    chk("rst_commit", 32'(commit_valid), 0);
    chk("rst_st_req", 32'(st_req), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_exc_pc", exc_pc, 0);
    chk("rst_st_addr", st_addr, 0);
    chk("rst_st_data", st_data, 0);

    // allocation from an empty ROB
    cyc(0, 1, 8, ROB_STATE_UNUSED, 0, 0, 0, 0);
    cyc(0, 1, 7, ROB_STATE_BUSY, 0, 0, 0, 0);
    cyc(0, 1, 6, ROB_STATE_BUSY, 0, 0, 0, 0);
    // back-to-back commits with parallel allocation
    repeat (3) cyc(0, 1, 5, ROB_STATE_COMPLETE, 0, 0, 0, 0);
    // store with 4-cycle cache latency; head operands change but captured values must hold
    cyc(0, 0, 4, ROB_STATE_WAITING_CACHE, 32'h100, 32'hDEAD, 0, 0);
    repeat (3) cyc(0, 0, 4, ROB_STATE_ACCESSING_CACHE, 32'h999, 32'h111, 0, 0);
    cyc(0, 0, 4, ROB_STATE_ACCESSING_CACHE, 32'h999, 32'h111, 0, 1);
    // store acknowledged on its first request cycle
    cyc(0, 0, 4, ROB_STATE_WAITING_CACHE, 32'h200, 32'hBEEF, 0, 0);
    cyc(0, 0, 4, ROB_STATE_ACCESSING_CACHE, 0, 0, 0, 1);
    // exception flush, allocation denied during the flush
    cyc(0, 0, 4, ROB_STATE_EXCEPTION, 0, 0, 32'h2040, 0);
    cyc(0, 1, 4, ROB_STATE_BUSY, 0, 0, 0, 0);
    // full ROB, then tail wrap
    repeat (2) cyc(0, 1, 0, ROB_STATE_BUSY, 0, 0, 0, 0);
    repeat (9) cyc(0, 1, 3, ROB_STATE_BUSY, 0, 0, 0, 0);
    // reset in the middle of a store, late ack ignored
    cyc(0, 0, 4, ROB_STATE_WAITING_CACHE, 32'h300, 32'h55, 0, 0);
    cyc(0, 0, 4, ROB_STATE_ACCESSING_CACHE, 0, 0, 0, 0);
    cyc(1, 0, 4, ROB_STATE_ACCESSING_CACHE, 0, 0, 0, 0);
    cyc(0, 0, 4, ROB_STATE_BUSY, 0, 0, 0, 1);
    cyc(0, 0, 4, ROB_STATE_BUSY, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) st = ROB_STATE_BUSY;
      else if (r <= 5) st = ROB_STATE_COMPLETE;
      else if (r <= 7) st = ROB_STATE_WAITING_CACHE;
      else if (r == 8) st = ROB_STATE_EXCEPTION;
      else st = ($urandom_range(0, 1) == 0) ? ROB_STATE_UNUSED : ROB_STATE_ACCESSING_CACHE;
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 8), st,
          $urandom, $urandom, $urandom, ($urandom_range(0, 2) == 0));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
